// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SRL / SLL / SRA / ROR).
// One registered column per shift-amount bit; column k shifts by 2^k when
// S[k] is set. Oversized amounts (any S bit at or above LOG2W) are flagged
// at acceptance and resolved in the last column. The pipeline stalls as a
// whole when the output is held. Latency LOG2W cycles, one op per cycle.
//
// Ports
//   CLK, RST              clock, async active-high reset
//   IN_VALID / IN_READY   input handshake (D, S, MODE)
//   MODE                  00 SRL, 01 SLL, 10 SRA, 11 ROR
//   FLUSH                 drop everything in flight, refuse input this cycle
//   OUT_VALID / OUT_READY output handshake (Y, Z)
//   Y, Z                  registered result and its zero flag

module shift_pipe_col #(
  parameter int WIDTH = 32,
  parameter int SH    = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (mode_i)
        2'b00:   data_o = data_i >> SH;
        2'b01:   data_o = data_i << SH;
        2'b10:   data_o = $unsigned($signed(data_i) >>> SH);
        default: data_o = {data_i[SH-1:0], data_i[WIDTH-1:SH]};
      endcase
    end
  end
endmodule

module shift_pipe #(
  parameter  int WIDTH = 32,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] S,
  input  logic [1:0]       MODE,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             Z
);
  logic                              adv;
  logic                              in_acc;
  logic [LOG2W-1:0]                  vld_pipe_q;
  logic [LOG2W-1:0][WIDTH-1:0]       dat_q, dat_d;
  logic [LOG2W-1:0][WIDTH-1:0]       col_in, col_out;
  logic [LOG2W-1:0][1:0]             mode_in;
  logic [LOG2W-1:0][LOG2W-1:0]       amt_in;
  logic [LOG2W-1:0]                  ovf_in;
  // Side-band only needs to reach the last column, so stage LOG2W-1 has none.
  logic [LOG2W-2:0][1:0]             mode_q;
  logic [LOG2W-2:0][LOG2W-1:0]       amt_q;
  logic [LOG2W-2:0]                  ovf_q;
  logic [WIDTH-1:0]                  y_d;
  logic                              z_q, z_d;

  // Whole pipe moves unless the output is held.
  assign adv      = !(vld_pipe_q[LOG2W-1] && !OUT_READY);
  assign IN_READY = adv && !FLUSH && !RST;
  assign in_acc   = IN_VALID && IN_READY;

  for (genvar k = 0; k < LOG2W; k++) begin : g_col
    if (k == 0) begin : g_head
      assign col_in[k]  = D;
      assign mode_in[k] = MODE;
      assign amt_in[k]  = S[LOG2W-1:0];
      assign ovf_in[k]  = |S[WIDTH-1:LOG2W];
    end else begin : g_body
      assign col_in[k]  = dat_q[k-1];
      assign mode_in[k] = mode_q[k-1];
      assign amt_in[k]  = amt_q[k-1];
      assign ovf_in[k]  = ovf_q[k-1];
    end

    shift_pipe_col #(.WIDTH(WIDTH), .SH(1 << k)) u_col (
      .data_i (col_in[k]),
      .mode_i (mode_in[k]),
      .en_i   (amt_in[k][k]),
      .data_o (col_out[k])
    );

    if (k < LOG2W-1) begin : g_mid
      assign dat_d[k] = col_out[k];
    end else begin : g_last
      assign dat_d[k] = y_d;
    end
  end

  // Oversize resolution: SRA's MSB is the sign all the way down the pipe, so
  // the last column's MSB is the fill value. ROR keeps the mod-WIDTH result.
  always_comb begin
    y_d = col_out[LOG2W-1];
    if (ovf_in[LOG2W-1]) begin
      case (mode_in[LOG2W-1])
        2'b00, 2'b01: y_d = '0;
        2'b10:        y_d = {WIDTH{col_out[LOG2W-1][WIDTH-1]}};
        default:      y_d = col_out[LOG2W-1];
      endcase
    end
    z_d = (y_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
      mode_q     <= '0;
      amt_q      <= '0;
      ovf_q      <= '0;
      z_q        <= 1'b0;
    end else if (FLUSH) begin
      vld_pipe_q <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[LOG2W-2:0], in_acc};
      dat_q      <= dat_d;
      mode_q     <= mode_in[LOG2W-2:0];
      amt_q      <= amt_in[LOG2W-2:0];
      ovf_q      <= ovf_in[LOG2W-2:0];
      z_q        <= z_d;
    end
  end

  assign OUT_VALID = vld_pipe_q[LOG2W-1];
  assign Y         = dat_q[LOG2W-1];
  assign Z         = z_q;
endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;
  localparam logic [1:0] SRL = 2'b00, SLL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY, FLUSH, OUT_VALID, OUT_READY, Z;
  logic [31:0] D, S, Y;
  logic [1:0]  MODE;

  int errs = 0, checks = 0;
  logic [32:0] expq[$];   // {z, y}
  logic [31:0] held_y;
  logic        held_v = 1'b0;

  shift_pipe #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .S(S), .MODE(MODE), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .Y(Y), .Z(Z)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge CLK); #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [31:0] d, input logic [31:0] s,
                      input logic [1:0] m, input logic [31:0] ey);
    bit ok = 0;
    IN_VALID = 1'b1; D = d; S = s; MODE = m;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CLK);
      if (IN_READY) begin
        expq.push_back({ey == 32'h0, ey});
        ok = 1;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    if (!ok) begin
      errs++; checks++;
      $display("FAIL send_timeout: d=%h not accepted", d);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 200) begin
      @(posedge CLK); t++;
    end
    #1;
    checks++;
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d results missing", expq.size());
    end
  endtask

  logic [31:0] stall_d[8] = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h80, 32'h80, 32'h80, 32'h80};
  logic [31:0] stall_e[8] = '{32'h80, 32'h40, 32'h20, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01};

  initial begin
    int lat, seen;
    RST = 1'b1; IN_VALID = 0; FLUSH = 0; OUT_READY = 1; D = 0; S = 0; MODE = 0;
    fork
      begin : main
        #3;
        chk("rst_in_ready", {31'b0, IN_READY}, 32'h0);
        chk("rst_out_valid", {31'b0, OUT_VALID}, 32'h0);
        chk("rst_y", Y, 32'h0);
        chk("rst_z", {31'b0, Z}, 32'h0);
        sync(); sync();
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", {31'b0, IN_READY}, 32'h1);
        sync();

        // Latency of a single op.
        send(32'h80000000, 31, SRL, 32'h00000001);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
          @(negedge CLK);
          if (OUT_VALID) lat = n;
        end
        chk("latency", lat, 5);
        drain(); sync();

        // Directed vectors, back to back.
        send(32'h80000000, 40,           SRA, 32'hFFFFFFFF);
        send(32'h12345678, 32,           SLL, 32'h00000000);
        send(32'h7FFFFFFF, 32'hFFFFFFFF, SRA, 32'h00000000);
        send(32'h00000001, 33,           ROR, 32'h80000000);
        send(32'hDEADBEEF, 0,            ROR, 32'hDEADBEEF);
        send(32'h00000001, 4,            SLL, 32'h00000010);
        send(32'hF0000000, 4,            SRA, 32'hFF000000);
        send(32'h12345678, 8,            ROR, 32'h78123456);
        send(32'hDEADBEEF, 0,            SRL, 32'hDEADBEEF);
        send(32'h80000001, 1,            SLL, 32'h00000002);
        send(32'h80000000, 31,           SRA, 32'hFFFFFFFF);
        send(32'h12345678, 4,            SRL, 32'h01234567);
        send(32'h12345678, 0,            SLL, 32'h12345678);
        send(32'h00000001, 32'h00000100, ROR, 32'h00000001);
        drain(); sync();

        // 8 ops with a 3-cycle output stall mid-stream.
        fork
          for (int i = 0; i < 8; i++) send(stall_d[i], i, SRL, stall_e[i]);
          begin
            repeat (6) @(posedge CLK);
            #1 OUT_READY = 1'b0;
            repeat (3) begin
              @(negedge CLK);
              chk("stall_in_ready", {31'b0, IN_READY}, 32'h0);
              @(posedge CLK); #1;
            end
            OUT_READY = 1'b1;
          end
        join
        drain(); sync();

        // Flush with three ops in flight.
        send(32'h11, 0, SLL, 32'h11);
        send(32'h22, 0, SLL, 32'h22);
        send(32'h33, 0, SLL, 32'h33);
        FLUSH = 1'b1; IN_VALID = 1'b1; D = 32'h44; S = 0; MODE = SLL;
        @(negedge CLK);
        chk("flush_in_ready", {31'b0, IN_READY}, 32'h0);
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        expq.delete();
        @(negedge CLK);
        chk("flush_out_valid", {31'b0, OUT_VALID}, 32'h0);
        seen = 0;
        repeat (10) begin @(negedge CLK); if (OUT_VALID) seen++; end
        chk("flush_no_stale", seen, 0);
        sync();

        // Async reset between edges with ops in flight and a held result.
        OUT_READY = 1'b0;
        send(32'h55, 0, SLL, 32'h55);
        send(32'h66, 0, SLL, 32'h66);
        send(32'h77, 0, SLL, 32'h77);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge CLK); if (OUT_VALID) seen = 1;
        end
        chk("pre_rst_valid", seen, 1);
        chk("pre_rst_y", Y, 32'h55);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, OUT_VALID}, 32'h0);
        chk("async_rst_y", Y, 32'h0);
        chk("async_rst_ready", {31'b0, IN_READY}, 32'h0);
        expq.delete();
        sync();
        RST = 1'b0; OUT_READY = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge CLK); if (OUT_VALID) seen++; end
        chk("rst_no_stale", seen, 0);
        sync();
        send(32'hA5A5A5A5, 4, ROR, 32'h5A5A5A5A);
        drain();
      end
      begin : monitor
        forever begin
          @(negedge CLK);
          if (!RST && OUT_VALID && !OUT_READY) begin
            if (held_v) chk("stall_hold_y", Y, held_y);
            held_v = 1'b1; held_y = Y;
          end else held_v = 1'b0;
          if (!RST && !FLUSH && OUT_VALID && OUT_READY) begin
            if (expq.size() == 0) begin
              errs++; checks++;
              $display("FAIL unexpected_out: got %h expected none", Y);
            end else begin
              logic [32:0] e;
              e = expq.pop_front();
              chk("result_y", Y, e[31:0]);
              chk("result_z", {31'b0, Z}, {31'b0, e[32]});
            end
          end
        end
      end
      begin : watchdog
        #200000;
        errs++; checks++;
        $display("FAIL watchdog: sim time limit reached");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
